// File: rtl/fp_round_pack.sv
// fp_round_pack: binary32 output stage. Takes an unpacked adder result,
// denormalises tiny values one bit per cycle, rounds, saturates on overflow
// and packs to a 32-bit word behind valid/ready handshakes.
module fp_round_pack #(
  parameter int MAX_SHIFT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  rounding_mode,
  input  logic        in_nan,
  input  logic        in_inf,
  input  logic        in_zero,
  input  logic        in_sign,
  input  logic [9:0]  in_exponent,
  input  logic [23:0] in_significand,
  input  logic        in_guard,
  input  logic        in_sticky,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_inexact
);
  localparam int CW = $clog2(MAX_SHIFT + 1);
  localparam logic signed [11:0] MAX_S = 12'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic               sign_q, guard_q, sticky_q, tiny_q;
  logic [2:0]         mode_q;
  logic [23:0]        sig_q;
  logic signed [11:0] exp_q;   // 12 bits: +511 input plus a rounding carry must not wrap
  logic [CW-1:0]      cnt_q;

  logic               accept, special, tiny_in;
  logic signed [11:0] exp_in, deficit;
  logic [CW-1:0]      cnt_init;
  logic [31:0]        special_word;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;
  assign special   = in_nan | in_inf | in_zero;
  assign exp_in    = {{2{in_exponent[9]}}, in_exponent};
  assign deficit   = -12'sd126 - exp_in;
  assign tiny_in   = exp_in < -12'sd126;
  assign cnt_init  = (deficit > MAX_S) ? CW'(MAX_SHIFT) : CW'(deficit);

  // NaN wins over inf, inf over zero; NaN is always the positive quiet NaN
  always_comb begin
    special_word = {in_sign, 31'd0};
    if (in_nan)      special_word = 32'h7FC0_0000;
    else if (in_inf) special_word = {in_sign, 8'hFF, 23'd0};
  end

  // rounding and packing of the (possibly denormalised) held operand
  logic               inc, up_ovf, ovf;
  logic [24:0]        sum;
  logic [23:0]        sig_r;
  logic signed [11:0] exp_r;
  logic [31:0]        packed_word;
  always_comb begin
    case (mode_q)
      3'd0:    inc = guard_q & (sticky_q | sig_q[0]);
      3'd1:    inc = guard_q;
      3'd2:    inc = !sign_q & (guard_q | sticky_q);
      3'd3:    inc = sign_q & (guard_q | sticky_q);
      default: inc = 1'b0;
    endcase
    sum   = {1'b0, sig_q} + {24'd0, inc};
    sig_r = sum[23:0];
    exp_r = exp_q;
    if (sum[24]) begin
      sig_r = sum[24:1];
      exp_r = exp_q + 12'sd1;
    end
    ovf    = exp_r > 12'sd127;
    up_ovf = (mode_q == 3'd0) || (mode_q == 3'd1) ||
             (mode_q == 3'd2 && !sign_q) || (mode_q == 3'd3 && sign_q);
    if (ovf)
      packed_word = up_ovf ? {sign_q, 8'hFF, 23'd0} : {sign_q, 8'hFE, 23'h7F_FFFF};
    else if (!sig_r[23])
      packed_word = {sign_q, 8'd0, sig_r[22:0]};
    else
      packed_word = {sign_q, 8'(exp_r + 12'sd127), sig_r[22:0]};
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state: specials skip rounding, tiny values detour through SHIFT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = special ? DONE : (tiny_in ? SHIFT : ROUND);
      SHIFT: if (cnt_q == CW'(1)) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, denormalising shift and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0; guard_q <= 1'b0; sticky_q <= 1'b0; tiny_q <= 1'b0;
      mode_q <= '0; sig_q <= '0; exp_q <= '0; cnt_q <= '0;
      result <= '0; flag_overflow <= 1'b0; flag_underflow <= 1'b0; flag_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_q   <= in_sign;
          mode_q   <= rounding_mode;
          sig_q    <= in_significand;
          guard_q  <= in_guard;
          sticky_q <= in_sticky;
          exp_q    <= exp_in;
          tiny_q   <= tiny_in;
          cnt_q    <= cnt_init;
          if (special) begin
            result         <= special_word;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
          end
        end
        SHIFT: begin
          sticky_q <= sticky_q | guard_q;
          guard_q  <= sig_q[0];
          sig_q    <= sig_q >> 1;
          exp_q    <= exp_q + 12'sd1;
          cnt_q    <= cnt_q - CW'(1);
        end
        ROUND: begin
          result         <= packed_word;
          flag_overflow  <= ovf;
          flag_inexact   <= guard_q | sticky_q | ovf;
          flag_underflow <= tiny_q & (guard_q | sticky_q | ovf);
        end
        default: ;
      endcase
    end
  end
endmodule
